// File: rtl/user_window_gen_if.sv
// -----------------------------------------------------------------------------
// user_window_gen_if
//   Bundles the control, ROM-read and window-output signals of user_window_gen.
//   The signal names keep the block's _i/_o suffixes, seen from the generator.
//
//   start_i      : one-cycle pulse that starts a frame pass
//   busy_o       : frame pass in progress
//   done_o       : one-cycle pulse after the final window is accepted
//   rom_req_o    : ROM word read request
//   rom_addr_o   : word-aligned ROM byte address
//   rom_data_i   : ROM read data, byte b = pixel x = 4k+b
//   rom_valid_i  : rom_data_i valid
//   win_valid_o  : 3x3 window presented downstream
//   win_ready_i  : downstream accepts the window
//   win_o        : window, byte 3r+c = pixel(y-1+r, x-1+c)
//   win_x_o/y_o  : centre coordinates of the presented window
//
//   master : the window generator
//   slave  : the environment (start source, ROM, downstream consumer)
// -----------------------------------------------------------------------------
interface user_window_gen_if;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        rom_valid_i;
    logic        win_valid_o;
    logic        win_ready_i;
    logic [71:0] win_o;
    logic [15:0] win_x_o;
    logic [15:0] win_y_o;

    modport master (
        input  start_i, rom_data_i, rom_valid_i, win_ready_i,
        output busy_o, done_o, rom_req_o, rom_addr_o,
               win_valid_o, win_o, win_x_o, win_y_o
    );

    modport slave (
        output start_i, rom_data_i, rom_valid_i, win_ready_i,
        input  busy_o, done_o, rom_req_o, rom_addr_o,
               win_valid_o, win_o, win_x_o, win_y_o
    );
endinterface

// File: rtl/user_window_gen.sv
// -----------------------------------------------------------------------------
// user_window_gen
//   Streams one image frame out of a word-organised ROM (four 8-bit pixels per
//   32-bit word, row-major) and produces every fully-populated 3x3 window of
//   that frame, in raster order, for a downstream edge-detect stage.
//
//   Parameters
//     ImgWidth  : image width in pixels, multiple of 4, >= 4
//     ImgHeight : image height in pixels, >= 3
//     BaseAddr  : word-aligned byte address of pixel (0,0)
//
//   Ports
//     clk_i : clock, all state updates on the rising edge
//     rst_i : synchronous active-high reset
//     bus   : user_window_gen_if.master (start/busy/done, ROM read channel,
//             window valid/ready channel with centre coordinates)
//
//   Operation
//     IDLE  -> FETCH on start_i.
//     FETCH  raises the ROM request for word k, then WAIT.
//     WAIT   holds the request until rom_valid_i, latches the word, then PUSH.
//     PUSH   feeds the four pixels of the latched word, one per cycle, through
//            two line buffers and a 3x3 shift window; stalls while a window is
//            presented but not accepted.
//     DRAIN  waits for the last window to be accepted, pulses done_o.
// -----------------------------------------------------------------------------
module user_window_gen #(
    parameter int unsigned ImgWidth  = 16,
    parameter int unsigned ImgHeight = 16,
    parameter logic [31:0] BaseAddr  = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    user_window_gen_if.master  bus
);

    localparam int unsigned XW = $clog2(ImgWidth);
    localparam int unsigned YW = $clog2(ImgHeight);

    localparam logic [XW-1:0] XLast = XW'(ImgWidth - 1);
    localparam logic [YW-1:0] YLast = YW'(ImgHeight - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PUSH,
        S_DRAIN
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e          state_q,     state_d;
    logic [XW-1:0]   x_q,         x_d;          // column of the next pixel
    logic [YW-1:0]   y_q,         y_d;          // row of the next pixel
    logic [1:0]      byte_q,      byte_d;       // pixel index within word_q
    logic [31:0]     word_q,      word_d;       // latched ROM word
    logic [31:0]     rom_addr_q,  rom_addr_d;   // doubles as the word pointer
    logic            rom_req_q,   rom_req_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;
    logic            win_valid_q, win_valid_d;
    logic [8:0][7:0] win_q,       win_d;        // byte 3r+c, c=2 is newest column
    logic [15:0]     win_x_q,     win_x_d;
    logic [15:0]     win_y_q,     win_y_d;

    // Line buffers: line0 holds row y-2, line1 holds row y-1, indexed by column.
    logic [7:0]      line0_mem [ImgWidth];
    logic [7:0]      line1_mem [ImgWidth];

    logic [7:0]      pix;
    logic [7:0]      line0_rd;
    logic [7:0]      line1_rd;
    logic            push_en;
    logic            last_pixel;

    assign pix        = word_q[{byte_q, 3'b000} +: 8];
    assign line0_rd   = line0_mem[x_q];
    assign line1_rd   = line1_mem[x_q];
    assign last_pixel = (x_q == XLast) && (y_q == YLast);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned;
        // an unassigned path in combinational logic would infer a latch.
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        byte_d      = byte_q;
        word_d      = word_q;
        rom_addr_d  = rom_addr_q;
        rom_req_d   = rom_req_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        win_d       = win_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        push_en     = 1'b0;
        // A presented window drops once accepted; ready without valid is a no-op.
        win_valid_d = win_valid_q & ~bus.win_ready_i;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d    = S_FETCH;
                    x_d        = '0;
                    y_d        = '0;
                    byte_d     = '0;
                    rom_addr_d = BaseAddr;
                    rom_req_d  = 1'b1;
                    busy_d     = 1'b1;
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Only one request is ever outstanding, and data is taken only
                // here, so a stray rom_valid_i elsewhere cannot touch word_q.
                if (bus.rom_valid_i) begin
                    word_d    = bus.rom_data_i;
                    rom_req_d = 1'b0;
                    state_d   = S_PUSH;
                end
            end

            S_PUSH: begin
                // A pending, unaccepted window freezes the whole pixel pipeline
                // so the presented window and its coordinates stay stable.
                if (!win_valid_q || bus.win_ready_i) begin
                    push_en = 1'b1;

                    for (int r = 0; r < 3; r++) begin
                        win_d[3*r]     = win_q[3*r + 1];
                        win_d[3*r + 1] = win_q[3*r + 2];
                    end
                    win_d[2] = line0_rd;
                    win_d[5] = line1_rd;
                    win_d[8] = pix;

                    // The window only counts once all three columns belong to
                    // the current row band, which also means the line buffers
                    // have been written by this frame.
                    if (y_q >= YW'(2) && x_q >= XW'(2)) begin
                        win_valid_d = 1'b1;
                        win_x_d     = 16'(x_q) - 16'd1;
                        win_y_d     = 16'(y_q) - 16'd1;
                    end

                    if (x_q == XLast) begin
                        x_d = '0;
                        if (y_q != YLast) begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end

                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if (last_pixel) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d    = S_FETCH;
                            rom_addr_d = rom_addr_q + 32'd4;
                            rom_req_d  = 1'b1;
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (!win_valid_q || bus.win_ready_i) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            byte_q      <= '0;
            word_q      <= '0;
            rom_addr_q  <= '0;
            rom_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            byte_q      <= byte_d;
            word_q      <= word_d;
            rom_addr_q  <= rom_addr_d;
            rom_req_q   <= rom_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
        end
    end

    // NOTE: the line buffers have no reset; every entry read for an emitted
    // window was written earlier in the same frame, so old contents never leak.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            line0_mem[x_q] <= line1_rd;
            line1_mem[x_q] <= pix;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all registered)
    // -------------------------------------------------------------------------
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.rom_req_o   = rom_req_q;
    assign bus.rom_addr_o  = rom_addr_q;
    assign bus.win_valid_o = win_valid_q;
    assign bus.win_o       = win_q;
    assign bus.win_x_o     = win_x_q;
    assign bus.win_y_o     = win_y_q;

endmodule

// File: tb/tb_user_window_gen.sv
// -----------------------------------------------------------------------------
// tb_user_window_gen
//   Two generator instances share clock and reset: a 4x3 image with a fixed
//   three-word ROM and a 16x16 ramp image with random ROM latency.
// -----------------------------------------------------------------------------
module tb_user_window_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    user_window_gen_if s_if ();
    user_window_gen_if l_if ();

    user_window_gen #(
        .ImgWidth  (4),
        .ImgHeight (3),
        .BaseAddr  (32'h0)
    ) dut_s (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (s_if.master)
    );

    user_window_gen #(
        .ImgWidth  (16),
        .ImgHeight (16),
        .BaseAddr  (32'h100)
    ) dut_l (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (l_if.master)
    );

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [71:0] W0 = 72'h0A0908_060504_020100;
    localparam logic [71:0] W1 = 72'h0B0A09_070605_030201;

    logic [31:0] s_rom [3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
    int          s_lat = 1;
    logic [31:0] s_req_log [$];
    int          s_addr_err = 0;
    logic [71:0] s_win [$];
    logic [15:0] s_wx [$];
    logic [15:0] s_wy [$];
    int          base_done_cyc = -1;

    logic [31:0] l_req_log [$];
    int          l_addr_err = 0;

    // ---------------- ROM model, small image ----------------
    initial begin : s_rom_model
        logic [31:0] a;
        int          lat;
        s_if.rom_valid_i = 1'b0;
        s_if.rom_data_i  = '0;
        forever begin
            @(negedge clk);
            if (s_if.rom_req_o === 1'b1 && !rst) begin
                a   = s_if.rom_addr_o;
                lat = s_lat;
                s_req_log.push_back(a);
                for (int i = 1; i < lat; i++) begin
                    @(negedge clk);
                    if (s_if.rom_req_o === 1'b1 && !rst && s_if.rom_addr_o !== a) s_addr_err++;
                end
                @(posedge clk);
                #1;
                s_if.rom_valid_i = 1'b1;
                s_if.rom_data_i  = (a < 32'd12) ? s_rom[a[3:2]] : 32'hEEEEEEEE;
                @(posedge clk);
                #1;
                s_if.rom_valid_i = 1'b0;
            end
        end
    end

    // ---------------- ROM model, 16x16 ramp, random latency ----------------
    initial begin : l_rom_model
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        int          idx;
        l_if.rom_valid_i = 1'b0;
        l_if.rom_data_i  = '0;
        forever begin
            @(negedge clk);
            if (l_if.rom_req_o === 1'b1 && !rst) begin
                a   = l_if.rom_addr_o;
                lat = int'($urandom_range(1, 8));
                l_req_log.push_back(a);
                for (int i = 1; i < lat; i++) begin
                    @(negedge clk);
                    if (!rst && (l_if.rom_req_o !== 1'b1 || l_if.rom_addr_o !== a)) l_addr_err++;
                end
                idx = int'((a - 32'h100) >> 2);
                for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'((4*idx + b) & 255);
                @(posedge clk);
                #1;
                l_if.rom_valid_i = 1'b1;
                l_if.rom_data_i  = d;
                @(posedge clk);
                #1;
                l_if.rom_valid_i = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic pulse_start_small();
        @(posedge clk);
        #1;
        s_if.start_i = 1'b1;
        @(posedge clk);
        #1;
        s_if.start_i = 1'b0;
    endtask

    // Observes the small instance until a done pulse (plus a few cycles), with
    // optional ready back-pressure after the first window and an optional
    // extra start pulse at cycle start_at.
    task automatic collect_small(input int stall, input int start_at, input int budget,
                                 output int n_done, output int done_cyc,
                                 output int held_cycles, output int hold_err,
                                 output bit timed_out);
        int          cyc;
        int          post;
        int          stall_left;
        bit          first_seen;
        bit          holding;
        logic [71:0] held;
        cyc = 0; post = 0; stall_left = 0; first_seen = 1'b0; holding = 1'b0; held = '0;
        n_done = 0; done_cyc = -1; held_cycles = 0; hold_err = 0; timed_out = 1'b1;
        s_win.delete(); s_wx.delete(); s_wy.delete();
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            s_if.start_i = (cyc == start_at);
            if (s_if.done_o === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (s_if.win_valid_o === 1'b1 && !first_seen) begin
                first_seen = 1'b1;
                if (stall > 0) begin
                    s_if.win_ready_i = 1'b0;
                    stall_left = stall;
                end
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) s_if.win_ready_i = 1'b1;
            end
            if (s_if.win_valid_o === 1'b1) begin
                if (holding && s_if.win_o !== held) hold_err++;
                if (s_if.win_ready_i) begin
                    s_win.push_back(s_if.win_o);
                    s_wx.push_back(s_if.win_x_o);
                    s_wy.push_back(s_if.win_y_o);
                    holding = 1'b0;
                end else begin
                    held = s_if.win_o;
                    holding = 1'b1;
                    held_cycles++;
                end
            end
            if (n_done > 0) begin
                post++;
                if (post >= 4) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        s_if.start_i     = 1'b0;
        s_if.win_ready_i = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if ({s_if.busy_o, s_if.done_o, s_if.rom_req_o, s_if.win_valid_o} !== 4'b0) begin
            n_fail++; $display("FAIL reset_s_ctrl: got %b expected 0000",
                {s_if.busy_o, s_if.done_o, s_if.rom_req_o, s_if.win_valid_o});
        end
        n_assert++;
        if (s_if.rom_addr_o !== 32'h0 || s_if.win_o !== 72'h0) begin
            n_fail++; $display("FAIL reset_s_data: addr %h win %h expected 0", s_if.rom_addr_o, s_if.win_o);
        end
        n_assert++;
        if ({s_if.win_x_o, s_if.win_y_o} !== 32'h0) begin
            n_fail++; $display("FAIL reset_s_xy: got %h expected 0", {s_if.win_x_o, s_if.win_y_o});
        end
        n_assert++;
        if ({l_if.busy_o, l_if.done_o, l_if.rom_req_o, l_if.win_valid_o} !== 4'b0 ||
            l_if.rom_addr_o !== 32'h0 || l_if.win_o !== 72'h0 || {l_if.win_x_o, l_if.win_y_o} !== 32'h0) begin
            n_fail++; $display("FAIL reset_l_outputs: addr %h win %h not all zero", l_if.rom_addr_o, l_if.win_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n_done, done_cyc, held_cycles, hold_err;
        bit timed_out;
        s_lat = 1;
        s_req_log.delete();
        pulse_start_small();
        n_assert++;
        if (s_if.busy_o !== 1'b1 || s_if.rom_req_o !== 1'b1 || s_if.rom_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL basic_start: busy %b req %b addr %h expected 1 1 0",
                s_if.busy_o, s_if.rom_req_o, s_if.rom_addr_o);
        end
        collect_small(0, 0, 300, n_done, done_cyc, held_cycles, hold_err, timed_out);
        base_done_cyc = done_cyc;
        n_assert++;
        if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done_o within budget"); end
        n_assert++;
        if (n_done !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
        n_assert++;
        if (s_req_log.size() !== 3 || s_req_log[0] !== 32'h0 || s_req_log[1] !== 32'h4 || s_req_log[2] !== 32'h8) begin
            n_fail++; $display("FAIL basic_addrs: %0d requests, expected 0x0 0x4 0x8", s_req_log.size());
        end
        n_assert++;
        if (s_win.size() !== 2) begin
            n_fail++; $display("FAIL basic_win_count: got %0d expected 2", s_win.size());
        end else begin
            n_assert++;
            if (s_win[0] !== W0 || s_wx[0] !== 16'd1 || s_wy[0] !== 16'd1) begin
                n_fail++; $display("FAIL basic_win0: got %h (%0d,%0d) expected %h (1,1)", s_win[0], s_wx[0], s_wy[0], W0);
            end
            n_assert++;
            if (s_win[1] !== W1 || s_wx[1] !== 16'd2 || s_wy[1] !== 16'd1) begin
                n_fail++; $display("FAIL basic_win1: got %h (%0d,%0d) expected %h (2,1)", s_win[1], s_wx[1], s_wy[1], W1);
            end
        end
        n_assert++;
        if (s_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", s_if.busy_o); end
    endtask

    task automatic test_stall();
        int n_done, done_cyc, held_cycles, hold_err;
        bit timed_out;
        s_lat = 1;
        s_req_log.delete();
        pulse_start_small();
        collect_small(5, 0, 300, n_done, done_cyc, held_cycles, hold_err, timed_out);
        n_assert++;
        if (timed_out || n_done !== 1) begin
            n_fail++; $display("FAIL stall_done: timeout %b done pulses %0d expected 0 1", timed_out, n_done);
        end
        n_assert++;
        if (held_cycles !== 5) begin n_fail++; $display("FAIL stall_held_cycles: got %0d expected 5", held_cycles); end
        n_assert++;
        if (hold_err !== 0) begin n_fail++; $display("FAIL stall_hold_stable: %0d changes while held, expected 0", hold_err); end
        n_assert++;
        if (s_win.size() !== 2) begin
            n_fail++; $display("FAIL stall_win_count: got %0d expected 2", s_win.size());
        end else begin
            n_assert++;
            if (s_win[0] !== W0 || s_win[1] !== W1 || s_wx[1] !== 16'd2) begin
                n_fail++; $display("FAIL stall_windows: got %h %h expected %h %h", s_win[0], s_win[1], W0, W1);
            end
        end
    endtask

    task automatic test_spurious();
        int n_done, done_cyc, held_cycles, hold_err;
        bit timed_out;
        s_lat = 1;
        repeat (3) @(posedge clk);
        #1;
        s_if.rom_valid_i = 1'b1;
        s_if.rom_data_i  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        s_if.rom_valid_i = 1'b0;
        @(posedge clk);
        #1;
        n_assert++;
        if (s_if.busy_o !== 1'b0 || s_if.rom_req_o !== 1'b0 || s_if.win_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL spurious_idle: busy %b req %b valid %b expected 0 0 0",
                s_if.busy_o, s_if.rom_req_o, s_if.win_valid_o);
        end
        s_req_log.delete();
        pulse_start_small();
        collect_small(0, 3, 300, n_done, done_cyc, held_cycles, hold_err, timed_out);
        n_assert++;
        if (timed_out || n_done !== 1) begin
            n_fail++; $display("FAIL spurious_done: timeout %b done pulses %0d expected 0 1", timed_out, n_done);
        end
        n_assert++;
        if (done_cyc !== base_done_cyc) begin
            n_fail++; $display("FAIL spurious_done_timing: done at cycle %0d expected %0d", done_cyc, base_done_cyc);
        end
        n_assert++;
        if (s_req_log.size() !== 3 || s_req_log[0] !== 32'h0 || s_req_log[2] !== 32'h8) begin
            n_fail++; $display("FAIL spurious_addrs: %0d requests, expected 0x0 0x4 0x8", s_req_log.size());
        end
        n_assert++;
        if (s_win.size() !== 2) begin
            n_fail++; $display("FAIL spurious_win_count: got %0d expected 2", s_win.size());
        end else begin
            n_assert++;
            if (s_win[0] !== W0 || s_win[1] !== W1) begin
                n_fail++; $display("FAIL spurious_windows: got %h %h expected %h %h", s_win[0], s_win[1], W0, W1);
            end
        end
    endtask

    task automatic test_ramp();
        int          cyc, post, n_win, n_done, hold_err, bad_addr, cx, cy;
        bit          timed_out, holding;
        logic [71:0] exp_w, held;
        cyc = 0; post = 0; n_win = 0; n_done = 0; hold_err = 0; bad_addr = 0;
        timed_out = 1'b1; holding = 1'b0; held = '0;
        l_req_log.delete();
        l_addr_err = 0;
        @(posedge clk);
        #1;
        l_if.start_i = 1'b1;
        @(posedge clk);
        #1;
        l_if.start_i = 1'b0;
        while (cyc < 10000) begin
            @(negedge clk);
            cyc++;
            l_if.win_ready_i = ($urandom_range(0, 3) != 0);
            if (l_if.done_o === 1'b1) n_done++;
            if (l_if.win_valid_o === 1'b1) begin
                if (holding && l_if.win_o !== held) hold_err++;
                if (l_if.win_ready_i) begin
                    holding = 1'b0;
                    cx = 1 + n_win % 14;
                    cy = 1 + n_win / 14;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            exp_w[8*(3*r + c) +: 8] = 8'(((cy - 1 + r) * 16 + (cx - 1 + c)) & 255);
                    n_assert++;
                    if (l_if.win_o !== exp_w || l_if.win_x_o !== 16'(cx) || l_if.win_y_o !== 16'(cy)) begin
                        n_fail++; $display("FAIL ramp_window_%0d: got %h (%0d,%0d) expected %h (%0d,%0d)",
                            n_win, l_if.win_o, l_if.win_x_o, l_if.win_y_o, exp_w, cx, cy);
                    end
                    n_win++;
                end else begin
                    held = l_if.win_o;
                    holding = 1'b1;
                end
            end
            if (n_done > 0) begin
                post++;
                if (post >= 4) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        l_if.win_ready_i = 1'b1;
        for (int i = 0; i < l_req_log.size(); i++)
            if (l_req_log[i] !== 32'h100 + 32'(4*i)) bad_addr++;
        n_assert++;
        if (timed_out || n_done !== 1) begin
            n_fail++; $display("FAIL ramp_done: timeout %b done pulses %0d expected 0 1", timed_out, n_done);
        end
        n_assert++;
        if (n_win !== 196) begin n_fail++; $display("FAIL ramp_win_count: got %0d expected 196", n_win); end
        n_assert++;
        if (l_req_log.size() !== 64 || bad_addr !== 0) begin
            n_fail++; $display("FAIL ramp_addrs: %0d requests, %0d out of sequence, expected 64 and 0",
                l_req_log.size(), bad_addr);
        end
        n_assert++;
        if (l_addr_err !== 0) begin
            n_fail++; $display("FAIL ramp_addr_stable: %0d request/address changes while waiting, expected 0", l_addr_err);
        end
        n_assert++;
        if (hold_err !== 0) begin
            n_fail++; $display("FAIL ramp_hold_stable: %0d changes while held, expected 0", hold_err);
        end
    endtask

    task automatic test_reset_mid();
        int  n_done, done_cyc, held_cycles, hold_err, cyc, late_done;
        bit  timed_out;
        s_lat = 4;
        s_req_log.delete();
        pulse_start_small();
        cyc = 0;
        while (s_req_log.size() < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_assert++;
        if (s_req_log.size() < 2) begin
            n_fail++; $display("FAIL rstmid_second_req: got %0d requests expected 2", s_req_log.size());
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_assert++;
        if ({s_if.busy_o, s_if.done_o, s_if.rom_req_o, s_if.win_valid_o} !== 4'b0) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b expected 0000",
                {s_if.busy_o, s_if.done_o, s_if.rom_req_o, s_if.win_valid_o});
        end
        n_assert++;
        if (s_if.rom_addr_o !== 32'h0 || s_if.win_o !== 72'h0 || {s_if.win_x_o, s_if.win_y_o} !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_data: addr %h win %h xy %h expected 0",
                s_if.rom_addr_o, s_if.win_o, {s_if.win_x_o, s_if.win_y_o});
        end
        late_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (s_if.done_o === 1'b1 || s_if.busy_o === 1'b1) late_done++;
        end
        n_assert++;
        if (late_done !== 0) begin
            n_fail++; $display("FAIL rstmid_no_done: %0d cycles with done/busy after abort, expected 0", late_done);
        end
        s_lat = 1;
        s_req_log.delete();
        pulse_start_small();
        collect_small(0, 0, 300, n_done, done_cyc, held_cycles, hold_err, timed_out);
        n_assert++;
        if (timed_out || n_done !== 1) begin
            n_fail++; $display("FAIL rstmid_restart_done: timeout %b done pulses %0d expected 0 1", timed_out, n_done);
        end
        n_assert++;
        if (s_req_log.size() !== 3 || s_req_log[0] !== 32'h0 || s_req_log[1] !== 32'h4) begin
            n_fail++; $display("FAIL rstmid_restart_addrs: %0d requests, expected 0x0 0x4 0x8", s_req_log.size());
        end
        n_assert++;
        if (s_win.size() !== 2) begin
            n_fail++; $display("FAIL rstmid_restart_win_count: got %0d expected 2", s_win.size());
        end else begin
            n_assert++;
            if (s_win[0] !== W0 || s_win[1] !== W1) begin
                n_fail++; $display("FAIL rstmid_restart_windows: got %h %h expected %h %h", s_win[0], s_win[1], W0, W1);
            end
        end
        n_assert++;
        if (s_addr_err !== 0) begin
            n_fail++; $display("FAIL small_addr_stable: %0d address changes while waiting, expected 0", s_addr_err);
        end
    endtask

    initial begin
        s_if.start_i     = 1'b0;
        s_if.win_ready_i = 1'b1;
        l_if.start_i     = 1'b0;
        l_if.win_ready_i = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_spurious();
        test_ramp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/user_window_gen.md
USER_WINDOW_GEN -- requirements
Module: user_window_gen

Interface
REQ-001 Parameter ImgWidth, default 16, image width in pixels; SHALL be a multiple of 4 and >= 4.
REQ-002 Parameter ImgHeight, default 16, image height in pixels; SHALL be >= 3.
REQ-003 Parameter BaseAddr, default 32'h0, word-aligned byte address of pixel (0,0) in ROM.
REQ-004 clk_i  in  1  the only clock; all state SHALL update on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 start_i  in  1  one-cycle pulse that starts one frame pass.
REQ-007 busy_o  out  1  high from the cycle after an accepted start until done_o.
REQ-008 done_o  out  1  one-cycle pulse when the last window of a frame is accepted.
REQ-009 rom_req_o  out  1  ROM word read request.
REQ-010 rom_addr_o  out  32  ROM byte address, always word-aligned.
REQ-011 rom_data_i  in  32  ROM read data; byte b holds pixel x = 4k+b.
REQ-012 rom_valid_i  in  1  rom_data_i valid, >= 1 cycle after request.
REQ-013 win_valid_o  out  1  a 3x3 window is presented to the edge-detect stage.
REQ-014 win_ready_i  in  1  downstream accepts the window.
REQ-015 win_o  out  72  window; byte 3r+c = pixel(y-1+r, x-1+c), r,c in 0..2.
REQ-016 win_x_o / win_y_o  out  16 each  centre coordinates of the presented window.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, PUSH, DRAIN.
REQ-018 IDLE: start_i -> FETCH with pixel pointer 0; start_i outside IDLE SHALL be ignored.
REQ-019 FETCH: assert rom_req_o with rom_addr_o = BaseAddr + 4*k (k = word index, row-major); go to WAIT next cycle.
REQ-020 WAIT: rom_req_o held high with stable address until rom_valid_i; on rom_valid_i, latch rom_data_i, deassert rom_req_o next cycle, go to PUSH.
REQ-021 At most one ROM request SHALL be outstanding.
REQ-022 PUSH: one pixel per cycle, byte 0 first; after byte 3, go to FETCH, or to DRAIN once the last word of the frame is consumed.
REQ-023 Each pushed pixel SHALL update two row line buffers (ImgWidth x 8 bits each) and a 3x3 shift window; its column is taken from the latched x, with no wrap-around into the previous row.
REQ-024 A window SHALL be produced when a pushed pixel at (x,y) has y >= 2 and x >= 2; its centre is (x-1, y-1).
REQ-025 Windows SHALL be emitted in raster order; total per frame = (ImgWidth-2)*(ImgHeight-2).
REQ-026 Handshake: win_valid_o SHALL stay high, and win_o, win_x_o, win_y_o stable, until win_valid_o && win_ready_i.
REQ-027 While win_valid_o && !win_ready_i, pixel pushes SHALL stall; ROM fetches MAY complete but SHALL not overwrite the latched word.
REQ-028 win_ready_i asserted without win_valid_o SHALL have no effect.
REQ-029 DRAIN: wait for acceptance of the final window, pulse done_o for one cycle, return to IDLE.
REQ-030 rom_valid_i outside WAIT SHALL be ignored.
REQ-031 Pixel and row counters SHALL be ceil(log2) sized and SHALL not wrap within a frame.

Reset
REQ-032 rst_i SHALL force IDLE, clear all counters and the window registers, and drive busy_o, done_o, rom_req_o, win_valid_o = 0 and rom_addr_o, win_o, win_x_o, win_y_o = 0 on the next clock edge.
REQ-033 rst_i mid-frame SHALL abort the frame without a done_o pulse; a subsequent start_i SHALL begin a fresh pass from word 0.
REQ-034 Line buffer contents need no reset; no window SHALL be emitted from stale data.

Verification
REQ-035 ImgWidth=4, ImgHeight=3, ROM words 0x03020100, 0x07060504, 0x0B0A0908, latency 1, ready tied high -> addresses 0x0, 0x4, 0x8; exactly 2 windows; first = bytes 00,01,02,04,05,06,08,09,0A at (1,1); second = bytes 01,02,03,05,06,07,09,0A,0B at (2,1); then one done_o pulse.
REQ-036 Same image, win_ready_i low for 5 cycles after the first win_valid_o -> win_o held constant for 5 cycles, no window lost or duplicated, same 2 windows.
REQ-037 ROM latency varied randomly from 1 to 8 cycles on a 16x16 ramp (pixel = x + 16y mod 256) -> 196 windows, each matching the reference model, with rom_addr_o stable while waiting.
REQ-038 rst_i asserted during the second ROM wait -> all outputs 0 next cycle, no done_o; a new start_i fetches 0x0 again and completes normally.
REQ-039 start_i pulsed while busy_o=1, and a spurious rom_valid_i pulsed in IDLE -> no effect on address sequence, window count, or done_o timing.
